// File: rtl/gray_pkg.sv
// Shared definitions for the Gray codec: mode encodings and error-counter sizing.
package gray_pkg;

  // in_mode / out_mode encodings
  localparam logic GC_MODE_DEC = 1'b0;  // Gray -> binary
  localparam logic GC_MODE_ENC = 1'b1;  // binary -> Gray

  // Step-error counter width and its saturation value
  localparam int unsigned            ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0]   ERR_CNT_MAX = '1;

endpackage

// File: rtl/gray_lane.sv
// gray_lane: one combinational Gray/binary converter lane.
// Ports:
//   data     - lane input value (Gray code when decoding, binary when encoding)
//   mode     - GC_MODE_DEC or GC_MODE_ENC
//   result_c - converted lane value (combinational)
module gray_lane
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  output logic [WIDTH-1:0] result_c
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;

  // Decode: running XOR from the MSB down, each binary bit folds in one Gray bit.
  always_comb begin
    logic acc;
    bin = '0;
    acc = 1'b0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      acc    = acc ^ data[i];
      bin[i] = acc;
    end
  end

  // Encode: each Gray bit is the XOR of adjacent binary bits.
  assign gray = data ^ (data >> 1);

  assign result_c = (mode == GC_MODE_ENC) ? gray : bin;

endmodule

// File: rtl/gray_codec.sv
// gray_codec: two-stage valid/ready pipeline converting LANES parallel lanes
// between Gray code and binary, with the direction chosen per beat.
// Optional Gray step checker compiled only when GRAY_CODEC_STEP_CHECK_EN is defined.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - input handshake; in_mode selects direction for the beat
//   in_data               - lane k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready   - output handshake
//   out_data, out_mode    - converted lanes and the beat's mode
//   step_err, err_cnt     - (checker only) per-lane Gray step violation, saturating count
module gray_codec
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_mode
`ifdef GRAY_CODEC_STEP_CHECK_EN
  ,
  output logic [LANES-1:0]       step_err,
  output logic [ERR_CNT_W-1:0]   err_cnt
`endif
);

  localparam int unsigned DW = LANES * WIDTH;

  logic          s1_valid;
  logic          s1_mode;
  logic [DW-1:0] s1_data;
  logic [DW-1:0] conv_c;
  logic          s1_adv;

  // S1 may move into S2 whenever S2 is empty or draining this cycle.
  assign s1_adv   = ~out_valid | out_ready;
  assign in_ready = rst_n & (~s1_valid | s1_adv);

  // Stage 1: input register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= GC_MODE_DEC;
      s1_data  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= in_mode;
        s1_data <= in_data;
      end
    end
  end

  // Conversion lanes between S1 and S2
  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    gray_lane #(.WIDTH(WIDTH)) u_lane (
      .data     (s1_data[k*WIDTH +: WIDTH]),
      .mode     (s1_mode),
      .result_c (conv_c[k*WIDTH +: WIDTH])
    );
  end

  // Stage 2: result register; holds while the sink stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= GC_MODE_DEC;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= conv_c;
        out_mode <= s1_mode;
      end
    end
  end

`ifdef GRAY_CODEC_STEP_CHECK_EN
  logic [DW-1:0]    gray_side_c;
  logic [DW-1:0]    hist;
  logic             hist_valid;
  logic [LANES-1:0] step_err_c;

  // The Gray-coded side is the input when decoding and the result when encoding.
  assign gray_side_c = (s1_mode == GC_MODE_ENC) ? conv_c : s1_data;

  // More than one bit differs iff clearing the lowest set bit leaves something set.
  always_comb begin
    logic [WIDTH-1:0] diff;
    step_err_c = '0;
    diff       = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      diff          = gray_side_c[k*WIDTH +: WIDTH] ^ hist[k*WIDTH +: WIDTH];
      step_err_c[k] = hist_valid && ((diff & (diff - WIDTH'(1))) != '0);
    end
  end

  // Checker state advances with the beat entering S2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist       <= '0;
      hist_valid <= 1'b0;
      step_err   <= '0;
      err_cnt    <= '0;
    end else if (s1_adv && s1_valid) begin
      step_err   <= step_err_c;
      hist       <= gray_side_c;
      hist_valid <= 1'b1;
      if ((|step_err_c) && (err_cnt != ERR_CNT_MAX)) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_gray_codec.sv
// Self-checking bench for gray_codec (WIDTH=4, LANES=2): vector table, round trip,
// backpressure, step checker (when GRAY_CODEC_STEP_CHECK_EN is defined) and reset flush.
module tb_gray_codec;
  import gray_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned L  = 2;
  localparam int unsigned DW = W * L;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic          in_mode   = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_mode;
`ifdef GRAY_CODEC_STEP_CHECK_EN
  logic [L-1:0]  step_err;
  logic [7:0]    err_cnt;
  bit            obs0[$];
`endif

  gray_codec #(.WIDTH(W), .LANES(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
`ifdef GRAY_CODEC_STEP_CHECK_EN
    ,
    .step_err  (step_err),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          mode;
    logic [DW-1:0] data;
    logic [L-1:0]  serr;
    logic [7:0]    cnt;
  } exp_t;

  typedef struct {
    logic          mode;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
  } vec_t;

  exp_t          sb[$];
  int            n_cmp    = 0;
  int            n_err    = 0;
  int            accepted = 0;
  int            stalls   = 0;
  logic [DW-1:0] m_hist   = '0;
  logic          m_hist_valid = 1'b0;
  int            m_cnt    = 0;

  function automatic logic [W-1:0] enc(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary bit i is the parity of all Gray bits at or above i.
  function automatic logic [W-1:0] dec(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < int'(W); i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Record the expected beat and advance the step-check model.
  task automatic push_expect(input logic mode, input logic [DW-1:0] din, input logic [DW-1:0] dout);
    exp_t          e;
    logic [DW-1:0] gs;
    logic [W-1:0]  g;
    e.mode = mode;
    e.data = dout;
    e.serr = '0;
    gs     = '0;
    for (int k = 0; k < int'(L); k++) begin
      g = mode ? enc(din[k*W +: W]) : din[k*W +: W];
      gs[k*W +: W] = g;
      e.serr[k] = m_hist_valid && ($countones(g ^ m_hist[k*W +: W]) > 1);
    end
    if ((|e.serr) && m_cnt < 255) m_cnt++;
    e.cnt        = 8'(m_cnt);
    m_hist       = gs;
    m_hist_valid = 1'b1;
    sb.push_back(e);
  endtask

  // Present a beat and wait (bounded) for it to be accepted.
  task automatic send(input logic mode, input logic [DW-1:0] din, input logic [DW-1:0] dout);
    int   waits;
    logic acc;
    waits    = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = din;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) break;
      waits++;
      if (waits > 200) begin
        check("accept_timeout", 32'(waits), 32'(0));
        in_valid = 1'b0;
        return;
      end
    end
    accepted++;
    stalls += waits;
    push_expect(mode, din, dout);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(sb.size()), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    sb.delete();
    m_hist_valid = 1'b0;
    m_cnt        = 0;
  endtask

  // Scoreboard: compare each beat as it is about to transfer on the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got data %0h with empty scoreboard, expected no beat (t=%0t)",
                 out_data, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_mode", 32'(out_mode), 32'(e.mode));
`ifdef GRAY_CODEC_STEP_CHECK_EN
        check("step_err", 32'(step_err), 32'(e.serr));
        check("err_cnt",  32'(err_cnt),  32'(e.cnt));
        obs0.push_back(step_err[0]);
`endif
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[6];
    logic [DW-1:0] a, g, snap;
    int            acc0, n;

    vecs[0] = '{1'b0, 8'hD8, 8'h9F};
    vecs[1] = '{1'b1, 8'h9F, 8'hD8};
    vecs[2] = '{1'b0, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 8'h00, 8'h00};
    vecs[4] = '{1'b0, 8'hF6, 8'hA4};
    vecs[5] = '{1'b1, 8'hF6, 8'h85};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 32'(in_ready), 32'(0));
    check("out_valid_reset",   32'(out_valid), 32'(0));
    check("out_data_reset",    32'(out_data), 32'(0));
    check("out_mode_reset",    32'(out_mode), 32'(0));
`ifdef GRAY_CODEC_STEP_CHECK_EN
    check("err_cnt_reset",  32'(err_cnt), 32'(0));
    check("step_err_reset", 32'(step_err), 32'(0));
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;

    // Latency of a single decode beat
    send(1'b0, 8'hD8, 8'h9F);
    check("latency_s1_only", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;
    check("latency_out_valid", 32'(out_valid), 32'(1));
    check("latency_out_data",  32'(out_data), 32'(8'h9F));
    wait_drain();

    // Vector table, back to back with alternating modes
    stalls = 0;
    for (int i = 0; i < 6; i++) send(vecs[i].mode, vecs[i].din, vecs[i].dout);
    check("table_throughput_stalls", 32'(stalls), 32'(0));
    wait_drain();

    // Round trip of all 16 values, encode and decode interleaved
    stalls = 0;
    for (int v = 0; v < 16; v++) begin
      a = {4'(15 - v), 4'(v)};
      g = {enc(4'(15 - v)), enc(4'(v))};
      send(1'b1, a, g);
      send(1'b0, g, a);
    end
    check("roundtrip_stalls", 32'(stalls), 32'(0));
    wait_drain();

    // Backpressure: sink stalled while 4 beats are offered
    out_ready = 1'b0;
    acc0 = accepted;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          a = {4'(i + 3), 4'(i * 5)};
          send(1'b0, a, {dec(4'(i + 3)), dec(4'(i * 5))});
        end
      end
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("bp_accepted_two", 32'(accepted - acc0), 32'(2));
    check("bp_in_ready_low", 32'(in_ready), 32'(0));
    check("bp_out_valid",    32'(out_valid), 32'(1));
    snap = out_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_data_hold", 32'(out_data), 32'(snap));
      check("bp_out_valid_hold", 32'(out_valid), 32'(1));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n = 0;
    while ((accepted - acc0) < 4 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("bp_accepted_all", 32'(accepted - acc0), 32'(4));
    wait_drain();

    // Step sequence on lane 0 from a clean history
    do_reset();
`ifdef GRAY_CODEC_STEP_CHECK_EN
    obs0.delete();
`endif
    send(1'b0, 8'h00, 8'h00);
    send(1'b0, 8'h01, 8'h01);
    send(1'b0, 8'h02, 8'h03);
    wait_drain();
`ifdef GRAY_CODEC_STEP_CHECK_EN
    check("step_seq_len", 32'(obs0.size()), 32'(3));
    if (obs0.size() == 3) begin
      check("step_seq_b0", 32'(obs0[0]), 32'(0));
      check("step_seq_b1", 32'(obs0[1]), 32'(0));
      check("step_seq_b2", 32'(obs0[2]), 32'(1));
    end
    check("step_seq_err_cnt", 32'(err_cnt), 32'(1));
`endif

    // Reset with both stages full
    do_reset();
    out_ready = 1'b0;
    send(1'b0, 8'h00, 8'h00);
    send(1'b1, 8'h00, 8'h00);
    @(negedge clk);
    check("full_out_valid", 32'(out_valid), 32'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("in_ready_mid_reset", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    sb.delete();
    m_hist_valid = 1'b0;
    m_cnt        = 0;
    out_ready    = 1'b1;
    check("rst_flush_out_valid", 32'(out_valid), 32'(0));
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_stale_beat", 32'(out_valid), 32'(0));
`ifdef GRAY_CODEC_STEP_CHECK_EN
    check("rst_err_cnt", 32'(err_cnt), 32'(0));
`endif
    // First post-reset beat is far from the pre-reset history but must not be flagged
    send(1'b0, 8'hFF, 8'hAA);
    send(1'b0, 8'hFE, 8'hAB);
    send(1'b0, 8'h00, 8'h00);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
